stream_wbus_writer: RTL and testbench

- Converts a valid/ready word stream into sequential write-port transactions (data/addr/valid/ready) toward a line/frame RAM.
- Sits directly upstream of the RAM write port and drives its master side.
- Handles one burst per start command: latches a base address and a length, generates auto-incrementing addresses with wrap-around, and signals completion.
- A 2-entry skid buffer gives full throughput with registered outputs.

---
 rtl/stream_wbus_writer.sv | 254 +++++++++++++++++++++++++
 tb/tb_stream_wbus_writer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_wbus_writer.sv
// ---------------------------------------------------------------------------
// stream_wbus_writer
//
// Turns a valid/ready word stream into sequential writes on a simple RAM
// write port (data/addr/valid/ready). One burst is handled per start command.
// The burst's base address and length are latched on start. Each accepted beat
// is tagged with an address that increments and wraps at RAM_DEPTH. A one-cycle
// done pulse marks the point where every beat has been written.
//
// A 2-entry buffer (output register + skid entry) gives full throughput. The
// buffer also keeps every output registered.
//
// Optional feature (macro STREAM_WBUS_WRITER_ERRCNT_EN):
//   adds err_cnt, a saturating count of bursts that finished with err_last=1.
//
// Ports:
//   clk        system clock
//   n_rst      asynchronous active-low reset
//   start      one-cycle burst command, honoured only in IDLE
//   base_addr  first write address (latched on accepted start)
//   len        burst length in words, 0..RAM_DEPTH (latched on accepted start)
//   s_data     stream word
//   s_valid    stream word valid
//   s_last     marks the final word of the burst (checked, not used to stop)
//   s_ready    block accepts a stream word (registered)
//   w_data     write data (registered)
//   w_addr     write address (registered)
//   w_valid    write request (registered)
//   w_ready    write port accepts the request
//   busy       high while the FSM is in RUN or FLUSH
//   done       one-cycle pulse when the burst completes
//   err_last   sticky s_last mismatch flag, cleared by an accepted start
//   err_cnt    (optional) bursts completed with err_last set, saturating
//
// Handshake semantics: a beat moves when valid && ready are both high at a
// rising clock edge. Once a valid is raised, that valid and its payload hold
// until the transfer happens. Neither valid depends combinationally on the
// matching ready.
//
// The FSM state is visible as the internal signal `state` (type state_t).
// ---------------------------------------------------------------------------
module stream_wbus_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 256,
  localparam int LB_RAM_DEPTH = $clog2(RAM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic [LB_RAM_DEPTH-1:0] base_addr,
  input  logic [LB_RAM_DEPTH:0]   len,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [LB_RAM_DEPTH-1:0] w_addr,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic                    busy,
  output logic                    done,
`ifdef STREAM_WBUS_WRITER_ERRCNT_EN
  output logic [15:0]             err_cnt,
`endif
  output logic                    err_last
);

  localparam logic [LB_RAM_DEPTH:0]   CNT_ONE  = {{LB_RAM_DEPTH{1'b0}}, 1'b1};
  localparam logic [LB_RAM_DEPTH-1:0] ADDR_ONE = {{(LB_RAM_DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_d;

  // Burst bookkeeping
  logic [LB_RAM_DEPTH:0]   len_q, len_d;
  logic [LB_RAM_DEPTH:0]   count_q, count_d;   // beats accepted so far
  logic [LB_RAM_DEPTH-1:0] addr_q, addr_d;     // address for the next beat
  logic                    err_last_d;

  // Skid entry (second buffer slot, behind the output register)
  logic                    skid_valid, skid_valid_d;
  logic [DATA_WIDTH-1:0]   skid_data, skid_data_d;
  logic [LB_RAM_DEPTH-1:0] skid_addr, skid_addr_d;

  // Output register next values
  logic                    w_valid_d;
  logic [DATA_WIDTH-1:0]   w_data_d;
  logic [LB_RAM_DEPTH-1:0] w_addr_d;
  logic                    s_ready_d;

  logic start_ok;
  logic s_acc;
  logic w_acc;
  logic out_free;
  logic drained;
  logic last_beat;

  assign start_ok  = (state == IDLE) && start;
  assign s_acc     = s_valid && s_ready;
  assign w_acc     = w_valid && w_ready;
  // The output register can take a new word if it is empty or if it is
  // being emptied at this edge.
  assign out_free  = w_acc || !w_valid;
  assign drained   = !w_valid && !skid_valid;
  // count_q < len_q whenever a beat is accepted, so count_q+1 cannot overflow.
  assign last_beat = ((count_q + CNT_ONE) == len_q);

  assign busy = (state != IDLE);
  assign done = (state == FLUSH) && drained;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (s_acc && last_beat) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (drained) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values: burst counters, 2-entry buffer, registered s_ready
  // -------------------------------------------------------------------------
  always_comb begin
    len_d        = len_q;
    addr_d       = addr_q;
    count_d      = count_q;
    err_last_d   = err_last;
    w_valid_d    = w_valid;
    w_data_d     = w_data;
    w_addr_d     = w_addr;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    skid_addr_d  = skid_addr;

    if (start_ok) begin
      len_d      = len;
      addr_d     = base_addr;
      count_d    = '0;
      err_last_d = 1'b0;
    end

    // s_ready is low in IDLE, so a start and a beat never coincide.
    if (s_acc) begin
      addr_d  = addr_q + ADDR_ONE;   // wraps naturally at RAM_DEPTH
      count_d = count_q + CNT_ONE;
      if (s_last != last_beat) begin
        err_last_d = 1'b1;
      end
    end

    if (out_free) begin
      if (skid_valid) begin
        // Oldest word moves up from the skid entry; a new beat takes its place.
        w_valid_d    = 1'b1;
        w_data_d     = skid_data;
        w_addr_d     = skid_addr;
        skid_valid_d = s_acc;
        if (s_acc) begin
          skid_data_d = s_data;
          skid_addr_d = addr_q;
        end
      end else begin
        w_valid_d = s_acc;
        if (s_acc) begin
          w_data_d = s_data;
          w_addr_d = addr_q;
        end
      end
    end else if (s_acc) begin
      // Output register is stalled; park the beat in the skid entry.
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
      skid_addr_d  = addr_q;
    end

    // s_ready is registered. It is computed from next-cycle occupancy and
    // count, so it drops in the same edge that fills the buffer or takes the
    // final beat.
    s_ready_d = (state_d == RUN) && !(w_valid_d && skid_valid_d) &&
                (count_d < len_d);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      len_q      <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      err_last   <= 1'b0;
      w_valid    <= 1'b0;
      w_data     <= '0;
      w_addr     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_addr  <= '0;
      s_ready    <= 1'b0;
    end else begin
      len_q      <= len_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_last   <= err_last_d;
      w_valid    <= w_valid_d;
      w_data     <= w_data_d;
      w_addr     <= w_addr_d;
      skid_valid <= skid_valid_d;
      skid_data  <= skid_data_d;
      skid_addr  <= skid_addr_d;
      s_ready    <= s_ready_d;
    end
  end

`ifdef STREAM_WBUS_WRITER_ERRCNT_EN
  // Counts bursts whose done pulse sees err_last set; saturates at all-ones.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_cnt <= '0;
    end else if (done && err_last && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_wbus_writer.sv
// ---------------------------------------------------------------------------
// tb_stream_wbus_writer
//
// Self-checking bench for stream_wbus_writer.
// - run_burst builds the expected write list for a burst before driving it.
//   Each entry holds the address (base + k) mod RAM_DEPTH and its data word.
//   The list goes into exp_q.
// - A separate monitor pops exp_q on every write handshake. It also checks
//   that stalled writes hold steady and that no more than two words are ever
//   in flight.
// - Each burst ends with checks on done timing, beat and write counts,
//   err_last and (when enabled) err_cnt.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_wbus_writer;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int LB    = $clog2(DEPTH);

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [LB-1:0] base_addr;
  logic [LB:0]   len;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [DW-1:0] w_data;
  logic [LB-1:0] w_addr;
  logic          w_valid;
  logic          w_ready;
  logic          busy;
  logic          done;
  logic          err_last;
`ifdef STREAM_WBUS_WRITER_ERRCNT_EN
  logic [15:0]   err_cnt;
`endif

  always #5 clk = ~clk;

  stream_wbus_writer #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .w_data    (w_data),
    .w_addr    (w_addr),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .busy      (busy),
    .done      (done),
`ifdef STREAM_WBUS_WRITER_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .err_last  (err_last)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [LB+DW-1:0] exp_q[$];
  int acc_total = 0;     // stream beats accepted (monitor only)
  int n_writes  = 0;     // write handshakes seen (monitor only)
  int occ_now   = 0;     // words held in the DUT after the coming edge
  int wbase     = 0;     // n_writes at start of the current burst
  int w_ready_mode = 0;  // 0: always 1, 1: random, 2: 5-cycle stall after first write
  int stall_cnt = 0;
  int err_cnt_model = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] held_data;
  logic [LB-1:0] held_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_ready"},  s_ready,  0);
    check({tag, "_w_valid"},  w_valid,  0);
    check({tag, "_w_data"},   w_data,   0);
    check({tag, "_w_addr"},   w_addr,   0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
    check({tag, "_err_last"}, err_last, 0);
  endtask

  // -------------------------------------------------------------------------
  // w_ready driver
  // -------------------------------------------------------------------------
  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (n_writes == wbase) stall_cnt = 0;
      case (w_ready_mode)
        1: w_ready = ($urandom_range(0, 1) == 1);
        2: begin
          if ((n_writes - wbase >= 1) && (stall_cnt < 5)) begin
            w_ready = 1'b0;
            stall_cnt++;
          end else begin
            w_ready = 1'b1;
          end
        end
        default: w_ready = 1'b1;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Monitor: sample on the falling edge; a handshake seen here completes at
  // the next rising edge.
  // -------------------------------------------------------------------------
  initial begin
    logic [LB+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        exp_q.delete();
        acc_total  = n_writes;
        stall_prev = 1'b0;
        occ_now    = 0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (!w_valid || (w_data !== held_data) || (w_addr !== held_addr)) begin
            errors++;
            $display("FAIL stall_stable: got v=%0b addr=0x%0h data=0x%0h expected v=1 addr=0x%0h data=0x%0h",
                     w_valid, w_addr, w_data, held_addr, held_data);
          end
        end
        if (s_valid && s_ready) acc_total++;
        if (w_valid && w_ready) begin
          n_writes++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected no write", w_addr, w_data);
          end else begin
            e = exp_q.pop_front();
            if ({w_addr, w_data} !== e) begin
              errors++;
              $display("FAIL write: got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                       w_addr, w_data, e[LB+DW-1:DW], e[DW-1:0]);
            end
          end
        end
        stall_prev = w_valid && !w_ready;
        held_data  = w_data;
        held_addr  = w_addr;
        occ_now    = acc_total - n_writes;
        checks++;
        if (occ_now > 2 || occ_now < 0) begin
          errors++;
          $display("FAIL occupancy: got %0d expected 0..2", occ_now);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver: one burst. Entered and left just after a rising edge.
  // err_beat >= 0 flips s_last on that beat; -1 gives a correct s_last.
  // -------------------------------------------------------------------------
  task automatic run_burst(input logic [LB-1:0] base, input int n, input int err_beat,
                           input int mode, input bit gaps, input bit poke,
                           input bit seq_data, input bit chk_peak);
    logic [DW-1:0] dat[$];
    bit            lst[$];
    logic [DW-1:0] d;
    logic [LB-1:0] a;
    logic [LB:0]   lenv;
    bit exp_err   = 0;
    bit done_seen = 0;
    int cyc  = 0;
    int peak = 0;
    int acc0;
    int wb;
    for (int k = 0; k < n; k++) begin
      d = seq_data ? DW'(k + 1) : DW'($urandom);
      a = LB'((int'(base) + k) % DEPTH);
      dat.push_back(d);
      lst.push_back((k == n - 1) ^ (k == err_beat));
      if (k == err_beat) exp_err = 1;
      exp_q.push_back({a, d});
    end
    lenv = n[LB:0];
    w_ready_mode = mode;
    wbase = n_writes;
    wb    = n_writes;
    acc0  = acc_total;
    start = 1'b1; base_addr = base; len = lenv;
    @(posedge clk); #1;
    // Scramble the command inputs: the latched copies must be used.
    start = 1'b0;
    base_addr = LB'($urandom);
    len = LB'($urandom);
    fork
      begin
        int k = 0;
        int g = 0;
        while (k < n && g < 4000) begin
          s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
          s_data  = dat[k];
          s_last  = lst[k];
          @(negedge clk);
          if (s_valid && s_ready) k++;
          @(posedge clk); #1;
          g++;
        end
        // Extra words beyond len must be refused.
        s_valid = 1'b1; s_data = '1; s_last = 1'b1;
        while (!done_seen && g < 8000) begin
          @(posedge clk); #1;
          g++;
        end
        s_valid = 1'b0; s_last = 1'b0;
      end
      begin
        while (!done_seen && cyc < 6000) begin
          @(negedge clk);
          cyc++;
          if (occ_now > peak) peak = occ_now;
          if (cyc == 1) check("busy_after_start", busy, 1);
          if (poke && cyc == 3) begin
            start = 1'b1; base_addr = LB'($urandom); len = 9'd3;
          end
          if (poke && cyc == 4) start = 1'b0;
          if (done) done_seen = 1;
        end
      end
    join
    start = 1'b0;
    check("done_seen", done_seen, 1);
    if (mode == 0 && !gaps) check("done_latency", cyc, (n == 0) ? 1 : n + 2);
    check("writes_left", exp_q.size(), 0);
    check("writes_issued", n_writes - wb, n);
    check("beats_accepted", acc_total - acc0, n);
    check("err_last", err_last, exp_err);
    if (exp_err && err_cnt_model < 65535) err_cnt_model++;
`ifdef STREAM_WBUS_WRITER_ERRCNT_EN
    check("err_cnt", err_cnt, err_cnt_model);
`endif
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    if (chk_peak) check("peak_occupancy", peak, 2);
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] rd[$];
    int wb;
    int k;
    int g;
    n_rst = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Directed bursts
    run_burst(8'h10, 4, -1, 0, 0, 0, 1, 0);   // (10,1)(11,2)(12,3)(13,4)
    run_burst(8'hFE, 4, -1, 0, 0, 0, 0, 0);   // FE FF 00 01
    run_burst(8'h33, 8, -1, 2, 0, 0, 0, 1);   // backpressure stall
    run_burst(8'h20, 3,  1, 0, 0, 0, 0, 0);   // early s_last
    run_burst(8'h55, 0, -1, 0, 0, 0, 0, 0);   // len 0
    run_burst(8'h60, 10, -1, 0, 0, 1, 0, 0);  // start during RUN ignored

    // Reset in the middle of a 6-word burst
    w_ready_mode = 0;
    wb = n_writes;
    wbase = n_writes;
    rd.delete();
    for (int i = 0; i < 6; i++) begin
      rd.push_back(DW'($urandom));
      exp_q.push_back({LB'(8'h40 + i), rd[i]});
    end
    start = 1'b1; base_addr = 8'h40; len = 9'd6;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; g = 0;
    while ((n_writes - wb < 2) && g < 200) begin
      s_valid = 1'b1;
      s_data  = rd[k % 6];
      s_last  = (k == 5);
      @(negedge clk);
      if (s_valid && s_ready) k++;
      @(posedge clk); #1;
      g++;
    end
    check("pre_reset_writes", n_writes - wb, 2);
    n_rst = 1'b0;
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    check_outputs_zero("midreset");
    err_cnt_model = 0;
`ifdef STREAM_WBUS_WRITER_ERRCNT_EN
    check("midreset_err_cnt", err_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    wb = n_writes;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_no_done", done, 0);
      check("post_reset_no_write", w_valid, 0);
    end
    @(posedge clk); #1;
    check("post_reset_writes", n_writes - wb, 0);
    run_burst(8'h80, 5, -1, 0, 0, 0, 0, 0);

    // Randomized bursts
    for (int i = 0; i < 16; i++) begin
      int n;
      int eb;
      n  = $urandom_range(0, 24);
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (n > 0) ? n - 1 : 0)) : -1;
      run_burst(LB'($urandom), n, eb, int'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1), 0, 0, 0);
    end
    run_burst(8'hC3, DEPTH, -1, 1, 1, 0, 0, 0);  // full-depth wrap

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
